// File: rtl/bank_read_drainer.sv
// bank_read_drainer: round-robin FIFO bank poller feeding a buffered valid/ready byte stream; BANK_READ_DRAINER_BACKOFF_EN adds an idle backoff after a full miss sweep
module bank_read_drainer #(
  parameter int OUT_DEPTH      = 4,
  parameter int BURST          = 4,
  parameter int BACKOFF_CYCLES = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  output logic                         rd_en,
  output logic [1:0]                   rd_id,
  input  logic [7:0]                   fifo_data,
  input  logic                         fifo_valid,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [7:0]                   m_data,
  output logic [1:0]                   m_bank,
  output logic [$clog2(OUT_DEPTH):0]   count,
  output logic [15:0]                  miss_cnt,
  output logic                         busy
);
  localparam int AW = $clog2(OUT_DEPTH);
  localparam int CW = AW + 1;

  if (OUT_DEPTH < 2 || OUT_DEPTH > 16 || (OUT_DEPTH & (OUT_DEPTH - 1)) != 0 ||
      BURST < 1 || BURST > 15 || BACKOFF_CYCLES < 1 || BACKOFF_CYCLES > 255) begin : g_bad_params
    $error("bank_read_drainer: parameter out of range");
  end

`ifdef BANK_READ_DRAINER_BACKOFF_EN
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, BACKOFF} state_t;
  logic [2:0] sweep_q, sweep_d;
  logic [7:0] bo_q, bo_d;
`else
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
`endif

  state_t          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [3:0]      burst_q, burst_d;
  logic [15:0]     miss_q, miss_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
  logic            rd_en_q, rd_en_d;
  logic            push, pop;
  logic [9:0]      mem [OUT_DEPTH];

  // next-state: FSM, bank pointer/burst bookkeeping and buffer occupancy
  always_comb begin
    push     = (state_q == WAIT) && fifo_valid;
    pop      = (count_q != '0) && m_ready;
    count_d  = count_q + CW'(push) - CW'(pop);
    head_d   = head_q + AW'(pop);
    tail_d   = tail_q + AW'(push);
    ptr_d    = ptr_q;
    burst_d  = burst_q;
    miss_d   = miss_q;
    state_d  = state_q;
`ifdef BANK_READ_DRAINER_BACKOFF_EN
    sweep_d  = sweep_q;
    bo_d     = bo_q;
`endif
    case (state_q)
      IDLE:  state_d = (enable && count_q < CW'(OUT_DEPTH)) ? ISSUE : IDLE;
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (fifo_valid) begin
          burst_d = burst_q + 4'd1;
          if (burst_d == 4'(BURST)) begin
            ptr_d   = ptr_q + 2'd1;
            burst_d = 4'd0;
          end
        end else begin
          ptr_d   = ptr_q + 2'd1;
          burst_d = 4'd0;
          miss_d  = (miss_q == 16'hFFFF) ? miss_q : miss_q + 16'd1;
        end
        state_d = (enable && count_d < CW'(OUT_DEPTH)) ? ISSUE : IDLE;
`ifdef BANK_READ_DRAINER_BACKOFF_EN
        sweep_d = fifo_valid ? 3'd0 : sweep_q + 3'd1;
        if (sweep_d == 3'd4) begin
          sweep_d = 3'd0;
          bo_d    = 8'd0;
          state_d = BACKOFF;
        end
`endif
      end
`ifdef BANK_READ_DRAINER_BACKOFF_EN
      BACKOFF: begin
        bo_d    = bo_q + 8'd1;
        state_d = (bo_q == 8'(BACKOFF_CYCLES - 1)) ? IDLE : BACKOFF;
      end
`endif
      default: state_d = IDLE;
    endcase
    rd_en_d = state_d == ISSUE;
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      burst_q <= 4'd0;
      miss_q  <= 16'd0;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      rd_en_q <= 1'b0;
`ifdef BANK_READ_DRAINER_BACKOFF_EN
      sweep_q <= 3'd0;
      bo_q    <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
      miss_q  <= miss_d;
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      rd_en_q <= rd_en_d;
`ifdef BANK_READ_DRAINER_BACKOFF_EN
      sweep_q <= sweep_d;
      bo_q    <= bo_d;
`endif
    end
  end

  // output buffer storage; occupancy alone decides validity, so no reset needed
  always_ff @(posedge clk) begin
    if (push) mem[tail_q] <= {ptr_q, fifo_data};
  end

  assign rd_en    = rd_en_q;
  assign rd_id    = ptr_q;
  assign m_valid  = count_q != '0;
  assign m_data   = mem[head_q][7:0];
  assign m_bank   = mem[head_q][9:8];
  assign count    = count_q;
  assign miss_cnt = miss_q;
  assign busy     = state_q != IDLE;
endmodule
